// File: rtl/return_addr_stack.sv
// Return-address stack for the fetch path.
// This is a circular LIFO of link addresses. When a push arrives while the
// stack is full, the oldest entry is overwritten. The pop result is
// registered and appears one cycle after the pop is sampled.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  output logic [AW-1:0] pop_addr,
  output logic          pop_valid,
  output logic [AW-1:0] top_addr,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];

  logic [PW-1:0] tp_q, tp_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] pop_addr_q, pop_addr_d;
  logic          pop_valid_q, pop_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] tp_m1;
  logic          is_empty, is_full;

  assign tp_m1    = tp_q - PW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // Next-state selection for the pointer, count, pop result, flags and entry write.
  always_comb begin
    tp_d        = tp_q;
    count_d     = count_q;
    pop_addr_d  = pop_addr_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_idx      = tp_q;

    if (pop && !is_empty) begin
      pop_addr_d  = mem_q[tp_m1];
      pop_valid_d = 1'b1;
      if (push) begin
        // The incoming call replaces the entry being returned from. Depth is unchanged.
        wr_en  = 1'b1;
        wr_idx = tp_m1;
      end else begin
        tp_d    = tp_m1;
        count_d = count_q - (PW+1)'(1);
      end
    end else begin
      if (pop) begin
        underflow_d = 1'b1;
      end
      if (push) begin
        wr_en  = 1'b1;
        wr_idx = tp_q;
        tp_d   = tp_q + PW'(1);
        if (is_full) begin
          // When the stack is full, slot tp already holds the oldest entry, so it is overwritten.
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + (PW+1)'(1);
        end
      end
    end
  end

  // Control and output registers. Reset takes priority over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q        <= '0;
      count_q     <= '0;
      pop_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      count_q     <= count_d;
      pop_addr_q  <= pop_addr_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage. It has no reset, and writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_idx] <= push_addr;
    end
  end

  assign top_addr  = is_empty ? '0 : mem_q[tp_m1];
  assign pop_addr  = pop_addr_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack. It applies one vector per cycle and
// compares against hand-computed expectations, then runs a few hand-written
// sequences.
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic [31:0] pop_addr;
  logic        pop_valid;
  logic [31:0] top_addr;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  return_addr_stack #(.DEPTH(8), .AW(32), .PW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .pop_addr  (pop_addr),
    .pop_valid (pop_valid),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic        rn;
    logic        psh;
    logic        pp;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic [31:0] top;
    logic        emp;
    logic        ful;
    logic        pv;
    logic [31:0] pa;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rn, input logic psh, input logic pp,
                              input logic [31:0] addr, input int cnt,
                              input logic [31:0] top, input logic emp,
                              input logic ful, input logic pv,
                              input logic [31:0] pa, input logic ovf,
                              input logic unf);
    vec_t v;
    v.rn = rn; v.psh = psh; v.pp = pp; v.addr = addr;
    v.cnt = cnt; v.top = top; v.emp = emp; v.ful = ful;
    v.pv = pv; v.pa = pa; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] pa;

    // Reset.
    add(0,0,0,32'h0,   0,32'h0,  1,0,0,32'h0,  0,0);
    // Three calls.
    add(1,1,0,32'h104, 1,32'h104,0,0,0,32'h0,  0,0);
    add(1,1,0,32'h208, 2,32'h208,0,0,0,32'h0,  0,0);
    add(1,1,0,32'h30C, 3,32'h30C,0,0,0,32'h0,  0,0);
    // Three returns on consecutive cycles.
    add(1,0,1,32'h0,   2,32'h208,0,0,1,32'h30C,0,0);
    add(1,0,1,32'h0,   1,32'h104,0,0,1,32'h208,0,0);
    add(1,0,1,32'h0,   0,32'h0,  1,0,1,32'h104,0,0);
    // Idle: the pulse drops and pop_addr holds.
    add(1,0,0,32'h0,   0,32'h0,  1,0,0,32'h104,0,0);
    // Pop while empty.
    add(1,0,1,32'h0,   0,32'h0,  1,0,0,32'h104,0,1);
    // Nine pushes into eight entries.
    for (int k = 1; k <= 9; k++) begin
      cnt = (k > 8) ? 8 : k;
      add(1,1,0,32'h10 + 32'(4*(k-1)), cnt, 32'h10 + 32'(4*(k-1)),
          0, (cnt == 8), 0, 32'h104, (k == 9), 1);
    end
    // Eight pops return 0x30 down to 0x14.
    for (int k = 1; k <= 8; k++) begin
      pa = 32'h30 - 32'(4*(k-1));
      add(1,0,1,32'h0, 8-k, (k == 8) ? 32'h0 : pa - 32'h4,
          (k == 8), 0, 1, pa, 1, 1);
    end
    // Push, then push and pop in the same cycle.
    add(1,1,0,32'hA0,  1,32'hA0, 0,0,0,32'h14, 1,1);
    add(1,1,1,32'hB0,  1,32'hB0, 0,0,1,32'hA0, 1,1);
    // Two more pushes, then reset asserted together with pop.
    add(1,1,0,32'h40,  2,32'h40, 0,0,0,32'hA0, 1,1);
    add(1,1,0,32'h44,  3,32'h44, 0,0,0,32'hA0, 1,1);
    add(0,0,1,32'h0,   0,32'h0,  1,0,0,32'h0,  0,0);
    // Push and pop together while empty: flags underflow and the push proceeds.
    add(1,1,1,32'h55,  1,32'h55, 0,0,0,32'h0,  0,1);
    add(1,0,1,32'h0,   0,32'h0,  1,0,1,32'h55, 0,1);

    rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rn; push = vecs[i].psh; pop = vecs[i].pp;
      push_addr = vecs[i].addr;
      @(posedge clk);
      #1;
      chk("count",     i, {28'h0, count}, vecs[i].cnt);
      chk("top_addr",  i, top_addr,       vecs[i].top);
      chk("empty",     i, {31'h0, empty}, {31'h0, vecs[i].emp});
      chk("full",      i, {31'h0, full},  {31'h0, vecs[i].ful});
      chk("pop_valid", i, {31'h0, pop_valid}, {31'h0, vecs[i].pv});
      chk("pop_addr",  i, pop_addr,       vecs[i].pa);
      chk("overflow",  i, {31'h0, overflow},  {31'h0, vecs[i].ovf});
      chk("underflow", i, {31'h0, underflow}, {31'h0, vecs[i].unf});
    end

    // The peek must not bypass a push that has not yet been clocked.
    @(negedge clk);
    rst_n = 1'b1; push = 1'b1; pop = 1'b0; push_addr = 32'h77;
    #1;
    chk("nobypass_top",   100, top_addr, 32'h0);
    chk("nobypass_empty", 100, {31'h0, empty}, 32'h1);
    @(posedge clk);
    #1;
    chk("after_push_top",   101, top_addr, 32'h77);
    chk("after_push_count", 101, {28'h0, count}, 32'h1);

    // Reset wins over a simultaneous push and pop.
    @(negedge clk);
    rst_n = 1'b0; push = 1'b1; pop = 1'b1; push_addr = 32'h88;
    @(posedge clk);
    #1;
    chk("rst_win_count", 102, {28'h0, count}, 32'h0);
    chk("rst_win_pv",    102, {31'h0, pop_valid}, 32'h0);
    chk("rst_win_pa",    102, pop_addr, 32'h0);
    chk("rst_win_unf",   102, {31'h0, underflow}, 32'h0);
    chk("rst_win_top",   102, top_addr, 32'h0);

    @(negedge clk);
    rst_n = 1'b1; push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_empty", 103, {31'h0, empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
